// File: rtl/reg_file_sb.sv
// reg_file_sb: 2R/1W register file with busy scoreboard,
// optional write bypass and a sequential soft-clear engine.
module reg_file_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  WRITE_ENABLE,
  input  logic [ADDR_WIDTH-1:0] WRITE_ADDRESS,
  input  logic [DATA_WIDTH-1:0] WRITE_DATA,
  input  logic [ADDR_WIDTH-1:0] DATA1_ADDRESS,
  input  logic [ADDR_WIDTH-1:0] DATA2_ADDRESS,
  output logic [DATA_WIDTH-1:0] DATA1,
  output logic [DATA_WIDTH-1:0] DATA2,
  output logic                  DATA1_BUSY,
  output logic                  DATA2_BUSY,
  input  logic                  ISSUE_ENABLE,
  input  logic [ADDR_WIDTH-1:0] ISSUE_ADDRESS,
  input  logic                  CLEAR_REQ,
  output logic                  CLEAR_BUSY
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    IDLE     = 1'b0,
    CLEARING = 1'b1
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;

  logic idle;
  logic wr_ok;
  logic iss_ok;

  assign idle = (state == IDLE);

  assign wr_ok = WRITE_ENABLE && idle &&
                 !(ZERO_REG && WRITE_ADDRESS == '0);

  assign iss_ok = ISSUE_ENABLE && idle &&
                  !(ZERO_REG && ISSUE_ADDRESS == '0);

  always_comb begin
    DATA1 = regs[DATA1_ADDRESS];
    if (BYPASS && wr_ok &&
        WRITE_ADDRESS == DATA1_ADDRESS)
      DATA1 = WRITE_DATA;
    if (ZERO_REG && DATA1_ADDRESS == '0)
      DATA1 = '0;
  end

  always_comb begin
    DATA2 = regs[DATA2_ADDRESS];
    if (BYPASS && wr_ok &&
        WRITE_ADDRESS == DATA2_ADDRESS)
      DATA2 = WRITE_DATA;
    if (ZERO_REG && DATA2_ADDRESS == '0)
      DATA2 = '0;
  end

  assign DATA1_BUSY = busy[DATA1_ADDRESS];
  assign DATA2_BUSY = busy[DATA2_ADDRESS];
  assign CLEAR_BUSY = (state == CLEARING);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= '0;
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (wr_ok)
            regs[WRITE_ADDRESS] <= WRITE_DATA;
          if (WRITE_ENABLE)
            busy[WRITE_ADDRESS] <= 1'b0;
          // issue after writeback: a new producer wins
          if (iss_ok)
            busy[ISSUE_ADDRESS] <= 1'b1;
          if (CLEAR_REQ)
            state <= CLEARING;
        end
        CLEARING: begin
          regs[cnt] <= '0;
          busy[cnt] <= 1'b0;
          cnt       <= cnt + 1'b1;
          if (cnt == ADDR_WIDTH'(DEPTH - 1))
            state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: vector table, directed corner cases and
// randomized traffic against an array-based reference model.
module tb_reg_file_sb;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  logic        we, ie, cr;
  logic [4:0]  wa, a1, a2, ia;
  logic [31:0] wd;
  logic [31:0] d1, d2;
  logic        b1, b2, cb;

  logic        x_we, x_ie, x_cr;
  logic [2:0]  x_wa, x_a1, x_a2, x_ia;
  logic [63:0] x_wd;
  logic [63:0] x_d1, x_d2;
  logic        x_b1, x_b2, x_cb;

  reg_file_sb dut (
    .CLK(CLK), .RESET(RESET),
    .WRITE_ENABLE(we), .WRITE_ADDRESS(wa),
    .WRITE_DATA(wd),
    .DATA1_ADDRESS(a1), .DATA2_ADDRESS(a2),
    .DATA1(d1), .DATA2(d2),
    .DATA1_BUSY(b1), .DATA2_BUSY(b2),
    .ISSUE_ENABLE(ie), .ISSUE_ADDRESS(ia),
    .CLEAR_REQ(cr), .CLEAR_BUSY(cb)
  );

  reg_file_sb #(
    .DATA_WIDTH(64), .ADDR_WIDTH(3),
    .ZERO_REG(1'b1), .BYPASS(1'b0)
  ) dut64 (
    .CLK(CLK), .RESET(RESET),
    .WRITE_ENABLE(x_we), .WRITE_ADDRESS(x_wa),
    .WRITE_DATA(x_wd),
    .DATA1_ADDRESS(x_a1), .DATA2_ADDRESS(x_a2),
    .DATA1(x_d1), .DATA2(x_d2),
    .DATA1_BUSY(x_b1), .DATA2_BUSY(x_b2),
    .ISSUE_ENABLE(x_ie), .ISSUE_ADDRESS(x_ia),
    .CLEAR_REQ(x_cr), .CLEAR_BUSY(x_cb)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: contents, busy flags, clear cycles left
  logic [31:0] mreg [32];
  logic        mbusy [32];
  int          clr_left;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mreg[i]  = '0;
      mbusy[i] = 1'b0;
    end
    clr_left = 0;
  endtask

  task automatic model_step();
    int idx;
    if (RESET) begin
      model_reset();
    end else if (clr_left > 0) begin
      idx = 32 - clr_left;
      mreg[idx]  = '0;
      mbusy[idx] = 1'b0;
      clr_left--;
    end else begin
      if (we) begin
        if (wa != 0) mreg[wa] = wd;
        mbusy[wa] = 1'b0;
      end
      if (ie && ia != 0) mbusy[ia] = 1'b1;
      if (cr) clr_left = 32;
    end
  endtask

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (clr_left == 0 && we && wa == a) return wd;
    return mreg[a];
  endfunction

  task automatic cmp(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string nm);
    cmp({nm, "_d1"}, 64'(d1), 64'(m_rd(a1)));
    cmp({nm, "_d2"}, 64'(d2), 64'(m_rd(a2)));
    cmp({nm, "_b1"}, 64'(b1), 64'(mbusy[a1]));
    cmp({nm, "_b2"}, 64'(b2), 64'(mbusy[a2]));
    cmp({nm, "_cb"}, 64'(cb), 64'(clr_left != 0));
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    we = 0; wa = 0; wd = 0; a1 = 0; a2 = 0;
    ie = 0; ia = 0; cr = 0;
    x_we = 0; x_wa = 0; x_wd = 0; x_a1 = 0; x_a2 = 0;
    x_ie = 0; x_ia = 0; x_cr = 0;
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  a1, a2;
    logic        ie;
    logic [4:0]  ia;
    logic [31:0] e1, e2;
    logic        eb1, eb2;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int n;
    tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b0, 5'd0,
               32'hDEADBEEF, 32'h0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b0, 5'd0,
               32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 5'd0, 32'h1, 5'd0, 5'd5, 1'b0, 5'd0,
               32'h0, 32'hDEADBEEF, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd7, 1'b1, 5'd7,
               32'h0, 32'h0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 5'd7, 32'h77, 5'd5, 5'd7, 1'b1, 5'd7,
               32'hDEADBEEF, 32'h77, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 5'd0, 32'h0, 5'd5, 5'd7, 1'b0, 5'd0,
               32'hDEADBEEF, 32'h77, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 5'd7, 32'h88, 5'd7, 5'd7, 1'b0, 5'd0,
               32'h88, 32'h88, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd7, 1'b0, 5'd0,
               32'h0, 32'h88, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd0,
               32'h0, 32'h0, 1'b0, 1'b0};
    tbl[9] = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd7, 1'b0, 5'd0,
               32'h0, 32'h88, 1'b0, 1'b0};

    idle_inputs();
    RESET = 1'b1;
    model_reset();
    tick();
    tick();
    RESET = 1'b0;

    for (int i = 0; i < 32; i++) begin
      a1 = 5'(i);
      a2 = 5'(31 - i);
      #1;
      cmp("rst_d1", 64'(d1), 64'h0);
      cmp("rst_b2", 64'(b2), 64'h0);
      check_all("rst");
    end

    for (int i = 0; i < 10; i++) begin
      we = tbl[i].we; wa = tbl[i].wa; wd = tbl[i].wd;
      a1 = tbl[i].a1; a2 = tbl[i].a2;
      ie = tbl[i].ie; ia = tbl[i].ia;
      #1;
      cmp($sformatf("vec%0d_d1", i), 64'(d1), 64'(tbl[i].e1));
      cmp($sformatf("vec%0d_d2", i), 64'(d2), 64'(tbl[i].e2));
      cmp($sformatf("vec%0d_b1", i), 64'(b1), 64'(tbl[i].eb1));
      cmp($sformatf("vec%0d_b2", i), 64'(b2), 64'(tbl[i].eb2));
      cmp($sformatf("vec%0d_cb", i), 64'(cb), 64'h0);
      tick();
    end
    idle_inputs();

    for (int i = 0; i < 400; i++) begin
      we = 1'($urandom_range(0, 1));
      wa = 5'($urandom_range(0, 31));
      wd = $urandom;
      a1 = ($urandom_range(0, 3) == 0) ? wa
                                       : 5'($urandom_range(0, 31));
      a2 = 5'($urandom_range(0, 31));
      ie = 1'($urandom_range(0, 1));
      ia = 5'($urandom_range(0, 31));
      cr = ($urandom_range(0, 39) == 0);
      #1;
      check_all("rnd");
      tick();
    end
    idle_inputs();
    n = 0;
    while (cb && n < 40) begin
      tick();
      n++;
    end
    cmp("rnd_drain", 64'(cb), 64'h0);

    for (int i = 1; i < 32; i++) begin
      we = 1; wa = 5'(i);
      wd = (32'(i) * 32'h01010101) ^ 32'hA5A50000;
      tick();
    end
    we = 0; ie = 1; ia = 5'd3;
    tick();
    ie = 0; a1 = 5'd3; a2 = 5'd31;
    #1;
    cmp("fill_b3", 64'(b1), 64'h1);
    cmp("fill_r31", 64'(d2), 64'(32'h1F1F1F1F ^ 32'hA5A50000));
    check_all("fill");
    cr = 1;
    tick();
    cr = 0;
    n = 0;
    while (cb && n < 100) begin
      we = 1; wa = 5'($urandom_range(1, 31)); wd = $urandom;
      ie = 1; ia = 5'($urandom_range(1, 31));
      a1 = wa; a2 = 5'($urandom_range(0, 31));
      #1;
      check_all("clr");
      tick();
      n++;
    end
    cmp("clear_len32", 64'(n), 64'd32);
    idle_inputs();
    for (int i = 0; i < 32; i++) begin
      a1 = 5'(i); a2 = 5'(i);
      #1;
      cmp("post_clr_d", 64'(d1), 64'h0);
      cmp("post_clr_b", 64'(b2), 64'h0);
    end

    we = 1; wa = 5'd20; wd = 32'h13572468;
    tick();
    we = 0; cr = 1;
    tick();
    cr = 0;
    for (int i = 0; i < 10; i++) tick();
    a1 = 5'd20; a2 = 5'd20;
    #1;
    cmp("mid_clr_d1", 64'(d1), 64'h13572468);
    cmp("mid_clr_cb", 64'(cb), 64'h1);
    RESET = 1'b1;
    #1;
    model_reset();
    cmp("async_rst_d1", 64'(d1), 64'h0);
    cmp("async_rst_cb", 64'(cb), 64'h0);
    check_all("async_rst");
    tick();
    RESET = 1'b0;
    we = 1; wa = 5'd20; wd = 32'hCAFE;
    #1;
    check_all("post_rst_wr");
    tick();
    we = 0;
    #1;
    cmp("post_rst_rd", 64'(d1), 64'hCAFE);
    cmp("post_rst_cb", 64'(cb), 64'h0);

    idle_inputs();
    x_we = 1; x_wa = 3'd7; x_wd = '1; x_a1 = 3'd7;
    #1;
    cmp("x_nobypass", x_d1, 64'h0);
    tick();
    x_we = 0; x_a2 = 3'd7;
    #1;
    cmp("x_r7_d1", x_d1, 64'hFFFF_FFFF_FFFF_FFFF);
    cmp("x_r7_d2", x_d2, 64'hFFFF_FFFF_FFFF_FFFF);
    x_we = 1; x_wa = 3'd5; x_wd = 64'hDEADBEEF; x_a1 = 3'd5;
    #1;
    cmp("x_r5_old", x_d1, 64'h0);
    tick();
    x_we = 0;
    #1;
    cmp("x_r5_new", x_d1, 64'hDEADBEEF);
    x_we = 1; x_wa = 3'd0; x_wd = 64'h1; x_a1 = 3'd0;
    tick();
    x_we = 0;
    #1;
    cmp("x_r0", x_d1, 64'h0);
    x_ie = 1; x_ia = 3'd3;
    tick();
    x_ie = 0; x_a1 = 3'd3; x_a2 = 3'd0;
    #1;
    cmp("x_busy3", 64'(x_b1), 64'h1);
    cmp("x_busy0", 64'(x_b2), 64'h0);
    cmp("x_cb_idle", 64'(x_cb), 64'h0);
    x_cr = 1;
    tick();
    x_cr = 0;
    n = 0;
    while (x_cb && n < 50) begin
      tick();
      n++;
    end
    cmp("x_clear_len8", 64'(n), 64'd8);
    x_a1 = 3'd7; x_a2 = 3'd3;
    #1;
    cmp("x_clr_d1", x_d1, 64'h0);
    cmp("x_clr_d2", x_d2, 64'h0);
    cmp("x_clr_b2", 64'(x_b2), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
